// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master = fetch side (issues requests), slave = memory side (returns words).
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns PC_F, one outstanding imem request, fills IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap and HALT state.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCsrc_E,
  input  logic [DATA_WIDTH-1:0] PCTarget_E,
  input  logic                  stall_F,
  input  logic                  flush_D,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instr_D,
  output logic [DATA_WIDTH-1:0] PC_D,
  output logic [DATA_WIDTH-1:0] PCPlus4_D,
  output logic                  valid_D,
  output logic                  misalign_trap_F
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DROP
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc_f, pc_next, pc_plus4, hold_buf, fetch_word;
  logic                  redirect, deliver, latch_hold, trap_set;

  assign pc_plus4       = pc_f + DATA_WIDTH'(4);
  assign fetch_word     = (state == S_HOLD) ? hold_buf : imem.imem_rdata;
  assign imem.imem_req  = (state == S_ISSUE);
  assign imem.imem_addr = pc_f;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Once halted, further redirects are ignored until reset.
  assign redirect = PCsrc_E && (state != S_HALT);
`else
  assign redirect = PCsrc_E;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc_f;
    deliver    = 1'b0;
    latch_hold = 1'b0;
    trap_set   = 1'b0;
    case (state)
      S_IDLE:  state_next = S_ISSUE;
      S_ISSUE: state_next = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (redirect) begin
          state_next = imem.imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem.imem_rvalid) begin
          if (!stall_F) begin
            deliver    = 1'b1;
            state_next = S_ISSUE;
          end else begin
            latch_hold = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_next = S_ISSUE;
        end else if (!stall_F) begin
          deliver    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_DROP: begin
        if (!redirect && imem.imem_rvalid) state_next = S_ISSUE;
      end
      default: state_next = state;
    endcase

    if (redirect) begin
      pc_next = PCTarget_E & ALIGN_MASK;
    end else if (deliver) begin
      pc_next = pc_plus4;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect && (PCTarget_E[1:0] != 2'b00)) begin
      trap_set   = 1'b1;
      pc_next    = PCTarget_E;
      state_next = S_HALT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc_f     <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state <= state_next;
      pc_f  <= pc_next;
      if (latch_hold) hold_buf <= imem.imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (flush_D || redirect) begin
      instr_D <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (!stall_F) begin
      if (deliver) begin
        instr_D   <= fetch_word;
        PC_D      <= pc_f;
        PCPlus4_D <= pc_plus4;
        valid_D   <= 1'b1;
      end else begin
        instr_D <= NOP_INSTR;
        valid_D <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap_F <= 1'b0;
    end else if (trap_set) begin
      misalign_trap_F <= 1'b1;
    end
  end
`else
  assign misalign_trap_F = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_set;
`endif

endmodule
